immediate_extend_pipe: RTL and testbench
========================================

IMMEDIATE_EXTEND_PIPE -- requirements
Module: immediate_extend_pipe

Interface
REQ-001 Parameter IN_W, default 16, immediate input width in bits.
REQ-002 Parameter OUT_W, default 32, extended output width; SHALL satisfy OUT_W >= IN_W + 2, elaboration error otherwise.
REQ-003 Clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 Rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  upstream presents a valid immediate.
REQ-006 in_ready  output  1  block can accept an immediate this cycle.
REQ-007 in_data  input  IN_W  raw immediate field.
REQ-008 in_mode  input  2  extension mode, sampled with in_data.
REQ-009 out_valid  output  1  out_data holds a valid result.
REQ-010 out_ready  input  1  downstream accepts the result this cycle.
REQ-011 out_data  output  OUT_W  extended result.
REQ-012 out_count  output  2  number of buffered results (0..2).

Function
REQ-013 Mode 00 (zero-extend) SHALL produce {(OUT_W-IN_W) zeros, in_data}.
REQ-014 Mode 01 (sign-extend) SHALL produce {(OUT_W-IN_W) copies of in_data[IN_W-1], in_data}.
REQ-015 Mode 10 (branch offset) SHALL produce the mode-01 result shifted left by 2, zeros in, upper 2 bits discarded, no wrap.
REQ-016 Mode 11 (upper immediate) SHALL produce {in_data, (OUT_W-IN_W) zeros}.
REQ-017 Result SHALL be computed from in_data/in_mode at acceptance and stored; later changes to inputs SHALL NOT affect stored entries.
REQ-018 Accept (push) occurs when in_valid && in_ready at a rising edge; deliver (pop) when out_valid && out_ready.
REQ-019 Storage SHALL be a 2-entry FIFO; results SHALL leave in acceptance order.
REQ-020 Latency: an immediate accepted at edge N SHALL be on out_data with out_valid=1 after edge N when the FIFO was empty (1 cycle, no combinational in-to-out path).
REQ-021 in_ready SHALL be 1 iff Rst_n=1 and out_count<2; it SHALL depend only on registered state and Rst_n, never on in_valid or out_ready.
REQ-022 out_valid SHALL equal (out_count != 0); out_data SHALL be the head entry.
REQ-023 Push and pop in the same edge with out_count=1: count stays 1, new entry becomes head.
REQ-024 Push and pop in the same edge with out_count=0: only push possible; count becomes 1.
REQ-025 out_count=2: push impossible (in_ready=0); pop SHALL reduce count to 1 and raise in_ready next cycle.
REQ-026 out_valid=1 with out_ready=0 SHALL hold out_data and out_valid stable until popped.
REQ-027 When out_count=0, out_data SHALL hold its last value (0 after reset); consumers SHALL ignore it.
REQ-028 FIFO pointers SHALL wrap modulo 2 without count corruption.

Reset
REQ-029 Rst_n low SHALL immediately (asynchronously) clear out_count to 0, out_valid to 0, out_data to 0, FIFO pointers to 0, and force in_ready to 0.
REQ-030 Reset mid-operation SHALL discard all buffered entries; no partial result SHALL appear after release.
REQ-031 First push SHALL be possible on the first rising edge with Rst_n=1 (in_ready=1 from release).

Verification
REQ-032 IN_W=16, OUT_W=32, mode 01, in_data 16'h8001 -> out_data 32'hFFFF8001, out_valid one cycle later; mode 00 same data -> 32'h00008001.
REQ-033 Mode 10, in_data 16'hFFFF -> 32'hFFFFFFFC; in_data 16'h4000 -> 32'h00010000; in_data 16'h7FFF -> 32'h0001FFFC.
REQ-034 Mode 11, in_data 16'h1234 -> 32'h12340000; mode 11, 16'h8000 -> 32'h80000000.
REQ-035 out_ready=0, push 16'h0001/01, 16'h0002/00, offer 16'h0003 -> in_ready 0 after second push, out_count 2, third held; raise out_ready -> outputs 32'h00000001, 32'h00000002, 32'h00000003 in order.
REQ-036 Continuous in_valid/out_ready=1 for 8 immediates -> one result per cycle, out_count constant 1, no drops or duplicates.
REQ-037 Assert Rst_n=0 mid-clock with out_count=2 -> out_valid, out_count, in_ready drop before next edge; after release first accepted 16'hABCD/01 -> 32'hFFFFABCD only.

Source files
------------

// File: rtl/immediate_extend_pipe_if.sv
// Handshake bundle for the immediate extension block: an upstream accept channel
// and a downstream delivery channel with occupancy reporting.
interface immediate_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [1:0]       out_count;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/immediate_extend_pipe.sv
// Extends a raw immediate (zero/sign/branch-offset/upper) at acceptance and buffers
// the results in a 2-entry FIFO with a registered output and no in-to-out path.
module immediate_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    immediate_extend_pipe_if.slave bus
);

    if (OUT_W < IN_W + 2) begin : g_width_check
        $error("immediate_extend_pipe: OUT_W must be at least IN_W + 2");
    end

    function automatic logic [OUT_W-1:0] extend_imm(input logic [IN_W-1:0] d,
                                                    input logic [1:0]      m);
        logic signed [OUT_W-1:0] sext;
        sext = {{(OUT_W-IN_W){d[IN_W-1]}}, d};
        case (m)
            2'b00:   return {{(OUT_W-IN_W){1'b0}}, d};
            2'b01:   return sext;
            2'b10:   return sext <<< 2;
            default: return {d, {(OUT_W-IN_W){1'b0}}};
        endcase
    endfunction

    logic [1:0]       count_q, count_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [OUT_W-1:0] mem_q [0:1];
    logic [OUT_W-1:0] mem_d [0:1];
    logic             push, pop;

    // in_ready looks only at registered occupancy and reset, never at in_valid/out_ready
    assign bus.in_ready  = rst_n && (count_q != 2'd2);
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_data  = out_data_q;
    assign bus.out_count = count_q;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = (count_q != 2'd0) && bus.out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = extend_imm(bus.in_data, bus.in_mode);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        // Output register mirrors the post-edge head; it holds its value once empty.
        out_data_d = (count_d != 2'd0) ? mem_d[rd_ptr_d] : out_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            out_data_q <= '0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            out_data_q <= out_data_d;
        end
    end

    // Storage cells are only read after being written, so they carry no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_immediate_extend_pipe.sv
// Scoreboard bench for immediate_extend_pipe: expected results are queued at
// acceptance and compared against the head while the DUT reports valid data.
module tb_immediate_extend_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    immediate_extend_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();

    immediate_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_pops   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_cur = '0;
    int          rdy_mode = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] d, input logic [1:0] m);
        logic [31:0] s;
        s = {{16{d[15]}}, d};
        case (m)
            2'd0:    model = {16'h0000, d};
            2'd1:    model = s;
            2'd2:    model = {s[29:0], 2'b00};
            default: model = {d, 16'h0000};
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Negedge monitor: state checks, head compare, then model the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            chk("count", 64'(bus.out_count), 64'(exp_q.size()));
            chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
            chk("in_ready", 64'(bus.in_ready), 64'(exp_q.size() < 2));
            if (exp_q.size() != 0) chk("head_data", 64'(bus.out_data), 64'(exp_q[0]));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                n_pops++;
            end
            if (bus.in_valid && bus.in_ready) exp_q.push_back(exp_cur);
        end
    end

    task automatic drive_in(input logic [15:0] d, input logic [1:0] m, input logic [31:0] e);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_mode  = m;
        exp_cur      = e;
    endtask

    task automatic wait_accept();
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] m, input logic [31:0] e);
        drive_in(d, m, e);
        wait_accept();
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin ok = 1; break; end
        end
        if (!ok) chk("drain_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] d;
        logic [1:0]  m;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = '0;
        bus.out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_count", 64'(bus.out_count), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", 64'(bus.in_ready), 64'd1);

        // Directed extension vectors with independently known results
        rdy_mode = 1;
        @(posedge clk);
        #1;
        send(16'h8001, 2'b01, 32'hFFFF8001);
        chk("latency_valid", 64'(bus.out_valid), 64'd1);
        chk("latency_data", 64'(bus.out_data), 64'hFFFF8001);
        send(16'h8001, 2'b00, 32'h00008001);
        send(16'hFFFF, 2'b10, 32'hFFFFFFFC);
        send(16'h4000, 2'b10, 32'h00010000);
        send(16'h7FFF, 2'b10, 32'h0001FFFC);
        send(16'h1234, 2'b11, 32'h12340000);
        send(16'h8000, 2'b11, 32'h80000000);
        drain();

        // Back-pressure: fill both entries, hold a third offer, then release
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send(16'h0001, 2'b01, 32'h00000001);
        send(16'h0002, 2'b00, 32'h00000002);
        drive_in(16'h0003, 2'b00, 32'h00000003);
        repeat (3) @(negedge clk);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        chk("full_count", 64'(bus.out_count), 64'd2);
        chk("full_hold_data", 64'(bus.out_data), 64'h00000001);
        rdy_mode = 1;
        wait_accept();
        drain();

        // Streaming: one result per cycle with occupancy steady at one
        n_pops = 0;
        for (int i = 0; i < 8; i++) begin
            d = 16'(16'h1000 + i * 16'h1111);
            m = 2'(i);
            send(d, m, model(d, m));
        end
        drain();
        chk("stream_pops", 64'(n_pops), 64'd8);

        // Random data/modes under random back-pressure
        rdy_mode = 2;
        for (int i = 0; i < 24; i++) begin
            d = 16'($urandom);
            m = 2'($urandom_range(0, 3));
            send(d, m, model(d, m));
        end
        rdy_mode = 1;
        drain();

        // Asynchronous reset with both entries occupied
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send(16'h5555, 2'b01, model(16'h5555, 2'b01));
        send(16'hAAAA, 2'b01, model(16'hAAAA, 2'b01));
        chk("pre_reset_count", 64'(bus.out_count), 64'd2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_count", 64'(bus.out_count), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("midrst_out_data", 64'(bus.out_data), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        rdy_mode = 1;
        n_pops = 0;
        send(16'hABCD, 2'b01, 32'hFFFFABCD);
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_pops", 64'(n_pops), 64'd1);
        chk("post_rst_idle", 64'(bus.out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
